// File: rtl/crt_if.sv
// CPU+CRT engine bundle: program fetch, pixel stream and run status.
// master = engine side, slave = ROM/display/controller side.
interface crt_if #(
  parameter int SCREEN_W = 40,
  parameter int SCREEN_H = 6,
  parameter int DATA_W   = 8,
  parameter int ROM_AW   = 8,
  parameter int SUM_W    = 32
);
  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

  logic                     start;
  logic [ROM_AW:0]          prog_len;
  logic [ROM_AW-1:0]        rom_addr;
  logic [DATA_W:0]          rom_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     pix_on;
  logic [XW-1:0]            pix_x;
  logic [YW-1:0]            pix_y;
  logic                     pix_last;
  logic                     busy;
  logic                     done;
  logic signed [SUM_W-1:0]  strength;
  logic signed [DATA_W-1:0] reg_x;

  modport master (
    input  start, prog_len, rom_data, pix_ready,
    output rom_addr, pix_valid, pix_on, pix_x, pix_y,
    output pix_last, busy, done, strength, reg_x
  );

  modport slave (
    output start, prog_len, rom_data, pix_ready,
    input  rom_addr, pix_valid, pix_on, pix_x, pix_y,
    input  pix_last, busy, done, strength, reg_x
  );
endinterface

// File: rtl/crt_engine.sv
// noop/addx CPU with a sprite-hit CRT pixel stream and
// signal-strength accumulation at periodic sample cycles.
module crt_engine #(
  parameter int SCREEN_W     = 40,
  parameter int SCREEN_H     = 6,
  parameter int DATA_W       = 8,
  parameter int ROM_AW       = 8,
  parameter int SPRITE_HALF  = 1,
  parameter int SAMPLE_FIRST = 20,
  parameter int SAMPLE_STEP  = 40,
  parameter int SUM_W        = 32
) (
  input  logic clk,
  input  logic rst,
  crt_if.master bus
);
  localparam int CW   = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int RW   = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam int NCYC = SCREEN_W * SCREEN_H;
  localparam int CYW  = $clog2(NCYC + 1);
  localparam int SMX  = (SAMPLE_FIRST > SAMPLE_STEP) ?
                        SAMPLE_FIRST : SAMPLE_STEP;
  localparam int SMW  = $clog2(SMX + 1);
  localparam int PW   = ROM_AW + 1;
  localparam int HW   = ((DATA_W > CW + 1) ? DATA_W : CW + 1) + 2;
  localparam logic signed [HW-1:0] SH_S = HW'(SPRITE_HALF);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC_A, S_EXEC_B, S_DONE
  } state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] x_q;
  logic [DATA_W-1:0]        imm_q;
  logic [PW-1:0]            ptr_q;
  logic [ROM_AW-1:0]        rom_addr_q;
  logic [CYW-1:0]           cycle_q;
  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic [SMW-1:0]           samp_q;
  logic signed [SUM_W-1:0]  strength_q;
  logic pix_valid_q, pix_on_q, pix_last_q;
  logic busy_q, done_q;

  logic                    hs, in_prog, is_addx;
  logic [PW-1:0]           ptr_d;
  logic [CW-1:0]           col_d;
  logic [RW-1:0]           row_d;
  logic [SMW-1:0]          samp_d;
  logic signed [SUM_W-1:0] strength_d;
  logic signed [SUM_W-1:0] cyc_s, x_s;

  function automatic logic hit(input logic [CW-1:0] c,
                               input logic signed [DATA_W-1:0] x);
    logic signed [HW-1:0] d;
    d = $signed(HW'(c)) - HW'(x);
    return (d <= SH_S) && (d >= -SH_S);
  endfunction

  function automatic logic is_last(input logic [CW-1:0] c,
                                   input logic [RW-1:0] r);
    return (c == CW'(SCREEN_W - 1)) && (r == RW'(SCREEN_H - 1));
  endfunction

  always_comb begin
    hs      = pix_valid_q & bus.pix_ready;
    in_prog = ptr_q < bus.prog_len;
    is_addx = bus.rom_data[DATA_W] & in_prog;
    ptr_d   = in_prog ? ptr_q + PW'(1) : ptr_q;
    col_d   = col_q + CW'(1);
    row_d   = row_q;
    if (col_q == CW'(SCREEN_W - 1)) begin
      col_d = '0;
      row_d = row_q + RW'(1);
    end
    cyc_s      = $signed(SUM_W'(cycle_q));
    x_s        = SUM_W'(x_q);
    samp_d     = samp_q - SMW'(1);
    strength_d = strength_q;
    // sample-down counter replaces a modulo on the cycle number
    if (samp_q == '0) begin
      samp_d     = SMW'(SAMPLE_STEP - 1);
      strength_d = strength_q + cyc_s * x_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= DATA_W'(1);
      imm_q       <= '0;
      ptr_q       <= '0;
      rom_addr_q  <= '0;
      cycle_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      samp_q      <= '0;
      strength_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_on_q    <= 1'b0;
      pix_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hs) begin
        samp_q     <= samp_d;
        strength_q <= strength_d;
        cycle_q    <= cycle_q + CYW'(1);
        if (!pix_last_q) begin
          col_q <= col_d;
          row_q <= row_d;
        end
      end
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q    <= S_FETCH;
          strength_q <= '0;
          x_q        <= DATA_W'(1);
          ptr_q      <= '0;
          rom_addr_q <= '0;
          cycle_q    <= CYW'(1);
          col_q      <= '0;
          row_q      <= '0;
          samp_q     <= SMW'(SAMPLE_FIRST - 1);
          busy_q     <= 1'b1;
        end
        S_FETCH: begin
          state_q     <= S_EXEC_A;
          pix_valid_q <= 1'b1;
          pix_on_q    <= hit(col_q, x_q);
          pix_last_q  <= is_last(col_q, row_q);
        end
        S_EXEC_A: if (hs) begin
          if (pix_last_q) begin
            state_q     <= S_DONE;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (is_addx) begin
            state_q    <= S_EXEC_B;
            imm_q      <= bus.rom_data[DATA_W-1:0];
            pix_on_q   <= hit(col_d, x_q);
            pix_last_q <= is_last(col_d, row_d);
          end else begin
            state_q     <= S_FETCH;
            pix_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            rom_addr_q  <= ptr_d[ROM_AW-1:0];
          end
        end
        S_EXEC_B: if (hs) begin
          pix_valid_q <= 1'b0;
          if (pix_last_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_FETCH;
            x_q        <= x_q + $signed(imm_q);
            ptr_q      <= ptr_d;
            rom_addr_q <= ptr_d[ROM_AW-1:0];
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_on    = pix_on_q;
  assign bus.pix_x     = col_q;
  assign bus.pix_y     = row_q;
  assign bus.pix_last  = pix_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.strength  = strength_q;
  assign bus.reg_x     = x_q;
endmodule

// File: tb/tb_crt_engine.sv
// Bench for crt_engine: per-cycle X list model of the CPU,
// pixel stream compared on every accepted pixel.
module tb_crt_engine;
  localparam int W = 40;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int NOP = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crt_if bus ();
  crt_engine dut (.clk(clk), .rst(rst), .bus(bus));

  logic [8:0] rom_mem [256];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int checks = 0;
  int errors = 0;
  int exp_x [N];
  bit exp_on [N];
  int exp_str, exp_fx;
  int pix_idx, done_cnt;
  bit dut_on [N];
  bit ref_on [N];
  bit rnd_ready;
  bit stall_p, p_on, p_last;
  int p_x, p_y;

  int aoc [146] = '{
    15, -11, 6, -3, 5, -1, -8, 13, 4, NOP,
    -1, 5, -1, 5, -1, 5, -1, 5, -1, -35,
    1, 24, -19, 1, 16, -11, NOP, NOP, 21, -15,
    NOP, NOP, -3, 9, 1, -3, 8, 1, 5, NOP,
    NOP, NOP, NOP, NOP, -36, NOP, 1, 7, NOP, NOP,
    NOP, 2, 6, NOP, NOP, NOP, NOP, NOP, 1, NOP,
    NOP, 7, 1, NOP, -13, 13, 7, NOP, 1, -33,
    NOP, NOP, NOP, 2, NOP, NOP, NOP, 8, NOP, -1,
    2, 1, NOP, 17, -9, 1, 1, -3, 11, NOP,
    NOP, 1, NOP, 1, NOP, NOP, -13, -19, 1, 3,
    26, -30, 12, -1, 3, 1, NOP, NOP, NOP, -9,
    18, 1, 2, NOP, NOP, 9, NOP, NOP, NOP, -1,
    2, -37, 1, 3, NOP, 15, -21, 22, -6, 1,
    NOP, 2, 1, NOP, -10, NOP, NOP, 20, 1, 2,
    2, -6, -11, NOP, NOP, NOP
  };

  string pic [6] = '{
    "##..##..##..##..##..##..##..##..##..##..",
    "###...###...###...###...###...###...###.",
    "####....####....####....####....####....",
    "#####.....#####.....#####.....#####.....",
    "######......######......######......####",
    "#######.......#######.......#######....."
  };

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act,
                       input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // CPU as a list of X values, one per cycle
  task automatic build_model(input int plen);
    int q[$];
    byte x;
    int fx, d;
    logic [8:0] ins;
    x = 1;
    fx = 1;
    for (int i = 0; q.size() < N; i++) begin
      ins = (i < plen) ? rom_mem[i] : 9'h000;
      q.push_back(int'(x));
      if (ins[8]) begin
        q.push_back(int'(x));
        x = x + byte'(ins[7:0]);
      end
      if (q.size() <= N) fx = int'(x);
    end
    for (int i = 0; i < N; i++) begin
      exp_x[i] = q[i];
      d = (i % W) - q[i];
      exp_on[i] = (d >= -1) && (d <= 1);
    end
    exp_str = 0;
    for (int c = 20; c <= N; c += 40) exp_str += c * exp_x[c - 1];
    exp_fx = fx;
  endtask

  function automatic string model_row(input int r);
    string s;
    s = "";
    for (int c = 0; c < W; c++)
      s = {s, exp_on[r * W + c] ? "#" : "."};
    return s;
  endfunction

  task automatic load_aoc();
    foreach (rom_mem[i]) rom_mem[i] = 9'h000;
    for (int i = 0; i < 146; i++)
      rom_mem[i] = (aoc[i] == NOP) ? 9'h000 : {1'b1, 8'(aoc[i])};
  endtask

  always @(negedge clk) begin
    if (stall_p) begin
      chk("stall_valid", bus.pix_valid, 1);
      chk("stall_on", bus.pix_on, p_on);
      chk("stall_x", bus.pix_x, p_x);
      chk("stall_y", bus.pix_y, p_y);
      chk("stall_last", bus.pix_last, p_last);
    end
    if (bus.done) done_cnt++;
    if (bus.pix_valid && bus.pix_ready && !rst) begin
      if (pix_idx < N) begin
        chk("pix_on", bus.pix_on, exp_on[pix_idx]);
        chk("pix_x", bus.pix_x, pix_idx % W);
        chk("pix_y", bus.pix_y, pix_idx / W);
        chk("pix_last", bus.pix_last, pix_idx == N - 1);
        chk("reg_x", bus.reg_x, exp_x[pix_idx]);
        dut_on[pix_idx] = bus.pix_on;
      end else begin
        chk("pix_overrun", pix_idx, N - 1);
      end
      pix_idx++;
    end
    stall_p = bus.pix_valid && !bus.pix_ready && !rst;
    p_on    = bus.pix_on;
    p_last  = bus.pix_last;
    p_x     = int'(bus.pix_x);
    p_y     = int'(bus.pix_y);
  end

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (done_cnt == 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done_cnt > 0, 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("pix_count", pix_idx, N);
    chk("busy_after", bus.busy, 0);
    chk("strength", bus.strength, exp_str);
    chk("final_x", bus.reg_x, exp_fx);
  endtask

  task automatic prep(input int plen, input bit rnd);
    bus.prog_len = 9'(plen);
    build_model(plen);
    rnd_ready = rnd;
    pix_idx = 0;
    done_cnt = 0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.prog_len = '0;
    rnd_ready = 1'b0;
    pix_idx = 0;
    done_cnt = 0;
    foreach (rom_mem[i]) rom_mem[i] = 9'h000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_reg_x", bus.reg_x, 1);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_strength", bus.strength, 0);

    rom_mem[0] = 9'h000;
    rom_mem[1] = {1'b1, 8'(3)};
    rom_mem[2] = {1'b1, 8'(-5)};
    prep(3, 1'b0);
    begin
      int lx [6] = '{1, 1, 1, 4, 4, -1};
      bit lo [6] = '{1, 1, 1, 1, 1, 0};
      for (int i = 0; i < 6; i++) chk("t2_model_x", exp_x[i], lx[i]);
      chk("t2_model_str", exp_str, -720);
      pulse_start();
      wait_done(5000);
      for (int i = 0; i < 6; i++) chk("t2_on", dut_on[i], lo[i]);
      chk("t2_x_hold", bus.reg_x, -1);
    end

    load_aoc();
    prep(146, 1'b0);
    chk("aoc_model_str", exp_str, 13140);
    for (int r = 0; r < H; r++) chk_s("aoc_row", model_row(r), pic[r]);
    pulse_start();
    wait_done(5000);
    chk("aoc_strength", bus.strength, 13140);
    for (int i = 0; i < N; i++) ref_on[i] = dut_on[i];

    prep(146, 1'b1);
    pulse_start();
    wait_done(20000);
    for (int i = 0; i < N; i++) chk("stall_seq", dut_on[i], ref_on[i]);

    prep(0, 1'b0);
    begin
      string s;
      s = "###";
      for (int c = 3; c < W; c++) s = {s, "."};
      for (int r = 0; r < H; r++) chk_s("p0_row", model_row(r), s);
    end
    pulse_start();
    repeat (50) @(negedge clk);
    chk("p0_busy_mid", bus.busy, 1);
    pulse_start();
    wait_done(5000);
    chk("p0_last_x", bus.pix_x, W - 1);
    chk("p0_last_y", bus.pix_y, H - 1);
    repeat (5) @(negedge clk);
    chk("p0_no_restart", bus.busy, 0);

    load_aoc();
    prep(146, 1'b1);
    pulse_start();
    n = 0;
    while (pix_idx < 100 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", pix_idx >= 100, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.pix_valid, 0);
    chk("abort_x", bus.reg_x, 1);
    chk("abort_str", bus.strength, 0);
    chk("abort_addr", bus.rom_addr, 0);
    chk("abort_no_done", done_cnt, 0);
    prep(146, 1'b0);
    pulse_start();
    wait_done(5000);
    chk("restart_str", bus.strength, 13140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
